// File: rtl/trng_capture_tx_pkg.sv
// Shared types and constants for the TRNG capture/UART dump path.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    LOAD     = 3'd2,
    SEND     = 3'd3,
    WAIT_ACK = 3'd4,
    WAIT_TX  = 3'd5
  } state_t;

  typedef enum logic {
    MODE_ASCII  = 1'b0,
    MODE_PACKED = 1'b1
  } mode_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

endpackage

// File: rtl/trng_capture_tx_debias.sv
// Von Neumann debiaser: pairs consecutive strobed bits, emits the first bit of a 01/10 pair.
module von_neumann_debias (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic strobe,
  input  logic bit_in,
  output logic valid_out,
  output logic bit_out
);

  logic phase;
  logic first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (strobe) begin
      phase <= ~phase;
      if (!phase) first <= bit_in;
    end
  end

  assign valid_out = strobe & phase & ~clr & (first ^ bit_in);
  assign bit_out   = first;

endmodule

// File: rtl/trng_capture_tx.sv
// Captures SAMPLE_COUNT (optionally debiased) entropy bits, then streams them to the UART.
module trng_capture_tx
  import trng_pkg::*;
#(
  parameter int SAMPLE_COUNT = 1000000,
  parameter int SAMPLE_DIV   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_bit,
  input  logic       start,
  input  logic       abort,
  input  logic       packed_mode,
  input  logic       debias_en,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_wr_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(SAMPLE_COUNT + 1);
  localparam int AW = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int XW = CW + 4;
  localparam logic [CW-1:0] COUNT_END = CW'(SAMPLE_COUNT);
  localparam logic [DW-1:0] DIV_END   = DW'(SAMPLE_DIV - 1);

  state_t state, next_state;
  mode_t  mode_q;
  logic   debias_q;
  logic   start_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] wr_addr, rd_addr;
  logic [XW-1:0] rd_sum, bit_idx;
  logic [7:0] load_byte;
  logic mem [SAMPLE_COUNT];

  logic raw_s, start_rise, go, strobe, last;
  logic vn_valid, vn_bit, mem_we, mem_wbit;

  assign raw_s      = sync_q[SYNC_STAGES-1];
  assign start_rise = start & ~start_q;
  assign go         = (state == IDLE) & start_rise & ~abort;
  assign strobe     = (state == CAPTURE) & (div_cnt == DIV_END) & (wr_addr != COUNT_END) & ~abort;
  assign mem_we     = strobe & (debias_q ? vn_valid : 1'b1);
  assign mem_wbit   = debias_q ? vn_bit : raw_s;
  // widened so a +8 step near the end of a short run cannot wrap
  assign rd_sum     = {4'b0, rd_addr} + XW'((mode_q == MODE_PACKED) ? 8 : 1);
  assign last       = rd_sum >= XW'(SAMPLE_COUNT);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  von_neumann_debias u_debias (
    .clk      (clk),
    .reset    (reset),
    .clr      (abort | go),
    .strobe   (strobe),
    .bit_in   (raw_s),
    .valid_out(vn_valid),
    .bit_out  (vn_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    tx_wr_en   = 1'b0;
    done       = 1'b0;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:     if (start_rise) next_state = CAPTURE;
        CAPTURE:  if (wr_addr == COUNT_END) next_state = LOAD;
        LOAD:     next_state = SEND;
        SEND: if (!tx_busy) begin
          tx_wr_en   = 1'b1;
          next_state = WAIT_ACK;
        end
        WAIT_ACK: if (tx_busy) next_state = WAIT_TX;
        WAIT_TX: if (!tx_busy) begin
          if (last) begin
            done       = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = LOAD;
          end
        end
        default:  next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    load_byte = '0;
    bit_idx   = '0;
    if (mode_q == MODE_ASCII) begin
      load_byte = mem[rd_addr[AW-1:0]] ? ASCII_ONE : ASCII_ZERO;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        bit_idx = {4'b0, rd_addr} + XW'(i);
        if (bit_idx < XW'(SAMPLE_COUNT)) load_byte[3'(7 - i)] = mem[bit_idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      start_q  <= 1'b1;
      mode_q   <= MODE_ASCII;
      debias_q <= 1'b0;
      div_cnt  <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_data  <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_bit};
      start_q <= start;
      if (go) begin
        mode_q   <= mode_t'(packed_mode);
        debias_q <= debias_en;
        div_cnt  <= '0;
        wr_addr  <= '0;
        rd_addr  <= '0;
      end
      if (state == CAPTURE && !abort) begin
        div_cnt <= (div_cnt == DIV_END) ? '0 : div_cnt + 1'b1;
        if (mem_we) wr_addr <= wr_addr + 1'b1;
        if (wr_addr == COUNT_END) rd_addr <= '0;
      end
      if (state == LOAD && !abort) tx_data <= load_byte;
      if (state == WAIT_TX && !tx_busy && !abort && !last) rd_addr <= rd_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr[AW-1:0]] <= mem_wbit;
  end

endmodule

// File: tb/tb_trng_capture_tx.sv
// Bench for trng_capture_tx: two instances (16 and 12 samples) checked against a bit/byte model.
module tb_trng_capture_tx;

  localparam int DIV  = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset, raw_bit, start, abort, packed_mode, debias_en;
  logic tx_busy[2], tx_wr_en[2], busy[2], done[2];
  logic [7:0] tx_data[2];
  logic [2:0] st[2];

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc;
  logic [7:0] exp_mem[2][64];
  int exp_n[2], exp_rd[2], done_cnt[2], exp_done[2], bcnt[2];
  logic [7:0] held[2];
  bit first_pend[2];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trng_capture_tx #(.SAMPLE_COUNT(16), .SAMPLE_DIV(DIV), .SYNC_STAGES(SYNC)) u16 (
    .clk(clk), .reset(reset), .raw_bit(raw_bit), .start(start), .abort(abort),
    .packed_mode(packed_mode), .debias_en(debias_en), .tx_busy(tx_busy[0]),
    .tx_data(tx_data[0]), .tx_wr_en(tx_wr_en[0]), .busy(busy[0]), .done(done[0]),
    .state_dbg(st[0])
  );

  trng_capture_tx #(.SAMPLE_COUNT(12), .SAMPLE_DIV(DIV), .SYNC_STAGES(SYNC)) u12 (
    .clk(clk), .reset(reset), .raw_bit(raw_bit), .start(start), .abort(abort),
    .packed_mode(packed_mode), .debias_en(debias_en), .tx_busy(tx_busy[1]),
    .tx_data(tx_data[1]), .tx_wr_en(tx_wr_en[1]), .busy(busy[1]), .done(done[1]),
    .state_dbg(st[1])
  );

  // UART stand-in: busy from the cycle after a write, for 20 cycles
  assign tx_busy[0] = (bcnt[0] != 0);
  assign tx_busy[1] = (bcnt[1] != 0);
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset)              bcnt[g] <= 0;
      else if (bcnt[g] != 0)  bcnt[g] <= bcnt[g] - 1;
      else if (tx_wr_en[g])   bcnt[g] <= 20;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int s);
    logic [7:0] db;
    db = 8'b0110_1100;  // per-strobe sequence 0,0,1,1,0,1,1,0 (index 0 = LSB)
    case (pat)
      0:       return (s % 2 == 0);
      1:       return 1'b1;
      default: return db[s % 8];
    endcase
  endfunction

  task automatic build(input int g, input int pat, input bit pk, input bit deb);
    logic b[64];
    logic [7:0] byt;
    int n, s, nn;
    nn = (g == 0) ? 16 : 12;
    n = 0;
    s = 0;
    while (n < nn && s < 10000) begin
      if (!deb) begin
        b[n] = pat_bit(pat, s);
        n++;
        s++;
      end else begin
        if (pat_bit(pat, s) != pat_bit(pat, s + 1)) begin
          b[n] = pat_bit(pat, s);
          n++;
        end
        s += 2;
      end
    end
    if (!pk) begin
      for (int i = 0; i < nn; i++) exp_mem[g][i] = b[i] ? 8'h31 : 8'h30;
      exp_n[g] = nn;
    end else begin
      exp_n[g] = (nn + 7) / 8;
      for (int j = 0; j < exp_n[g]; j++) begin
        byt = 8'h00;
        for (int t = 0; t < 8; t++)
          if (8 * j + t < nn) byt[7 - t] = b[8 * j + t];
        exp_mem[g][j] = byt;
      end
    end
    exp_rd[g] = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      for (int g = 0; g < 2; g++) begin
        if (tx_wr_en[g]) begin
          chk("wr_while_busy", int'(tx_busy[g]), 0);
          if (exp_rd[g] >= exp_n[g]) begin
            total++;
            bad++;
            $display("FAIL extra_byte: inst %0d got 0x%0h beyond %0d expected bytes", g, tx_data[g], exp_n[g]);
          end else begin
            chk("tx_data", int'(tx_data[g]), int'(exp_mem[g][exp_rd[g]]));
            exp_rd[g]++;
          end
          held[g] = tx_data[g];
          if (first_pend[g]) begin
            total++;
            if (cyc - start_cyc < ((g == 0) ? 16 : 12) * DIV + SYNC) begin
              bad++;
              $display("FAIL first_latency: inst %0d got %0d cycles required >= %0d", g,
                       cyc - start_cyc, ((g == 0) ? 16 : 12) * DIV + SYNC);
            end
            first_pend[g] = 1'b0;
          end
        end else if (tx_busy[g]) begin
          chk("tx_data_stable", int'(tx_data[g]), int'(held[g]));
        end
        if (done[g]) begin
          done_cnt[g]++;
          chk("done_all_sent", exp_rd[g], exp_n[g]);
        end
      end
    end
  end

  // abort_at: 0 none, 1 mid-capture, 2 when u16 first reaches WAIT_TX
  task automatic run(input int pat, input bit pk, input bit deb, input bit pulse, input int abort_at);
    bit fin;
    for (int g = 0; g < 2; g++) begin
      build(g, pat, pk, deb);
      first_pend[g] = 1'b1;
    end
    @(negedge clk);
    packed_mode = pk;
    debias_en   = deb;
    raw_bit     = pat_bit(pat, 0);
    start       = 1'b1;
    start_cyc   = cyc;
    fin = 1'b0;
    for (int n = 1; n <= 20000 && !fin; n++) begin
      @(negedge clk);
      if (n % DIV == 0) raw_bit = pat_bit(pat, n / DIV);
      if (n == 3) start = 1'b0;
      if (pulse && n == 60) start = 1'b1;
      if (pulse && n == 63) start = 1'b0;
      if ((abort_at == 1 && n == 30) || (abort_at == 2 && st[0] == 3'd5)) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int g = 0; g < 2; g++) begin
          chk("abort_state", int'(st[g]), 0);
          chk("abort_busy", int'(busy[g]), 0);
          exp_n[g] = 0;
          exp_rd[g] = 0;
          first_pend[g] = 1'b0;
        end
        fin = 1'b1;
      end else if (n > 3 && !busy[0] && !busy[1]) begin
        for (int g = 0; g < 2; g++) begin
          chk("bytes_sent", exp_rd[g], exp_n[g]);
          exp_done[g]++;
        end
        fin = 1'b1;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got busy=%0d/%0d required idle", busy[0], busy[1]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; abort = 1'b0; raw_bit = 1'b0;
    packed_mode = 1'b0; debias_en = 1'b0;
    for (int g = 0; g < 2; g++) begin
      exp_n[g] = 0; exp_rd[g] = 0; done_cnt[g] = 0; exp_done[g] = 0;
      held[g] = 8'h00; first_pend[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_tx_data", int'(tx_data[g]), 0);
      chk("reset_wr_en", int'(tx_wr_en[g]), 0);
      chk("reset_done", int'(done[g]), 0);
      chk("reset_busy", int'(busy[g]), 0);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) chk("start_thru_reset", int'(st[g]), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int g = 0; g < 2; g++) chk("start_with_abort", int'(st[g]), 0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("start_edge_consumed", int'(st[g]), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 1'b0, 1'b0, 1'b1, 0);
    chk("pin_ascii0", int'(exp_mem[0][0]), 'h31);
    chk("pin_ascii1", int'(exp_mem[0][1]), 'h30);
    chk("pin_ascii_n", exp_n[0], 16);

    run(1, 1'b1, 1'b0, 1'b0, 0);
    chk("pin_pk16_b1", int'(exp_mem[0][1]), 'hFF);
    chk("pin_pk12_b1", int'(exp_mem[1][1]), 'hF0);
    chk("pin_pk12_n", exp_n[1], 2);

    run(2, 1'b1, 1'b1, 1'b0, 0);
    chk("pin_vn16_b0", int'(exp_mem[0][0]), 'h55);
    chk("pin_vn12_b1", int'(exp_mem[1][1]), 'h50);

    run(0, 1'b0, 1'b0, 1'b0, 1);
    run(0, 1'b0, 1'b0, 1'b0, 2);

    run(2, 1'b0, 1'b1, 1'b1, 0);
    chk("pin_vn_ascii0", int'(exp_mem[0][0]), 'h30);
    chk("pin_vn_ascii1", int'(exp_mem[0][1]), 'h31);

    for (int g = 0; g < 2; g++) chk("done_count", done_cnt[g], exp_done[g]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
